pipeline_ctrl: RTL
==================

Name: pipeline_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage pipeline.
- Drives the en and flush inputs of the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB registers.
- Resolves load-use hazards, taken-branch redirects, multi-cycle MDU ops and data-memory wait states.
- Each *_flush output is ORed into the corresponding register's synchronous reset, so flush has priority over en at that register.

Parameters:
- MEM_TIMEOUT, 64, max consecutive MEM_WAIT cycles before fault; range 1..2^16-1.
- CNT_W, 32, width of the stall performance counter.
- REG_ADDR_W, 5, register index width.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high.
- id_rs1  in  REG_ADDR_W  rs1 of instruction in ID.
- id_rs2  in  REG_ADDR_W  rs2 of instruction in ID.
- id_use_rs1  in  1  ID instruction reads rs1.
- id_use_rs2  in  1  ID instruction reads rs2.
- ex_rd  in  REG_ADDR_W  destination of instruction in EX.
- ex_is_load  in  1  EX instruction is a load.
- ex_branch_taken  in  1  EX resolved a taken branch/jump.
- ex_mdu_op  in  1  EX instruction is mul/div (level).
- mdu_done  in  1  MDU result valid (1-cycle pulse).
- mdu_start  out  1  one-cycle MDU launch pulse.
- mem_req  in  1  MEM instruction is a load/store.
- dmem_ready  in  1  data memory completes the access this cycle.
- pc_en, ifid_en, idex_en, exmem_en, memwb_en  out  1 each  register enables.
- ifid_flush, idex_flush, exmem_flush, memwb_flush  out  1 each  bubble insert.
- mem_fault  out  1  sticky memory-timeout error.
- stall_cycles  out  CNT_W  saturating count of stalled cycles.

Behaviour:
- States: RUN, MEM_WAIT, MDU_WAIT, FAULT.
- Outputs are combinational from current state and inputs. State, timeout counter, stall_cycles and mem_fault are registered.
- Reset: state=RUN, counters=0, mem_fault=0. While reset=1, all *_en=0, all *_flush=1, mdu_start=0.
- Hazard terms:
  - load_use = ex_is_load && ex_rd!=0 && ((id_use_rs1 && id_rs1==ex_rd) || (id_use_rs2 && id_rs2==ex_rd)).
  - mem_stall = mem_req && !dmem_ready.
  - mdu_stall = ex_mdu_op && !mdu_done.
- Output priority, first matching row wins; unlisted en=1 and unlisted flush=0:
  1. FAULT: all en=0, all flush=0 (pipeline frozen until reset).
  2. mem_stall: all en=0 except memwb_en=1; memwb_flush=1; branch/load-use/MDU deferred.
  3. mdu_stall: pc_en=ifid_en=idex_en=0; exmem_flush=1.
  4. ex_branch_taken: ifid_flush=1, idex_flush=1, pc_en=1. Load-use is ignored.
  5. load_use: pc_en=ifid_en=0; idex_flush=1.
  6. Otherwise all en=1, no flush.
- Transitions:
  - RUN→MEM_WAIT on mem_stall; the timeout counter loads 1.
  - MEM_WAIT: counter increments each cycle mem_stall remains set.
  - MEM_WAIT→RUN when dmem_ready=1; stall releases that same cycle and the counter clears.
  - MEM_WAIT→FAULT when the counter reaches MEM_TIMEOUT with dmem_ready=0; mem_fault is set on that edge.
  - RUN→MDU_WAIT when mdu_stall && !mem_stall. mdu_start=1 only in this RUN cycle; never re-asserted while in MDU_WAIT.
  - MDU_WAIT→RUN on mdu_done. A mem_stall arriving in MDU_WAIT freezes per row 2; state stays MDU_WAIT.
  - mdu_done in the launch cycle (zero-latency MDU): no stall, no MDU_WAIT entry; mdu_start still pulses.
  - FAULT is exited only by reset.
- stall_cycles increments by 1 in any cycle where pc_en=0 and reset=0, including FAULT cycles. It saturates at 2^CNT_W-1.
- Reset mid-MEM_WAIT or mid-MDU_WAIT returns to RUN immediately; no mdu_start is issued.

Test Plan:
- Load x5 in EX, ID add uses rs2=x5 → one cycle with pc_en=0, ifid_en=0, idex_flush=1, then all en=1; stall_cycles=1.
- ex_branch_taken=1 together with a load-use match → ifid_flush=1, idex_flush=1, pc_en=1; no stall.
- mem_req=1, dmem_ready low for 3 cycles then high → pc/ifid/idex/exmem_en=0 and memwb_flush=1 for 3 cycles; release on 4th; state back to RUN; stall_cycles=3.
- MEM_TIMEOUT=4, dmem_ready never rises → mem_fault=1 after 4 waiting cycles; all en=0 thereafter; reset clears mem_fault=0 and state=RUN.
- ex_mdu_op=1, mdu_done after 5 cycles → mdu_start single pulse in cycle 0; exmem_flush=1 for 5 cycles; ex_branch_taken during MEM stall deferred until release.
- Reset asserted in MDU_WAIT → next cycle RUN, mdu_start=0; with CNT_W=4 and 20 stalled cycles, stall_cycles holds 15.

Source files
------------

// File: rtl/pipeline_ctrl_if.sv
// Pipeline control bus: hazard information flowing from the datapath into the
// stall/flush sequencer, and register enables/flushes flowing back out.
interface pipeline_ctrl_if #(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 32
);
  // Hazard sources from the ID, EX and MEM stages
  logic [REG_ADDR_W-1:0] id_rs1;
  logic [REG_ADDR_W-1:0] id_rs2;
  logic                  id_use_rs1;
  logic                  id_use_rs2;
  logic [REG_ADDR_W-1:0] ex_rd;
  logic                  ex_is_load;
  logic                  ex_branch_taken;
  logic                  ex_mdu_op;
  logic                  mdu_done;
  logic                  mem_req;
  logic                  dmem_ready;

  // Controls back to the PC, pipeline registers and MDU
  logic                  mdu_start;
  logic                  pc_en;
  logic                  ifid_en;
  logic                  idex_en;
  logic                  exmem_en;
  logic                  memwb_en;
  logic                  ifid_flush;
  logic                  idex_flush;
  logic                  exmem_flush;
  logic                  memwb_flush;
  logic                  mem_fault;
  logic [CNT_W-1:0]      stall_cycles;

  // Datapath side: reports hazards, obeys enables/flushes
  modport master (
    output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_is_load,
           ex_branch_taken, ex_mdu_op, mdu_done, mem_req, dmem_ready,
    input  mdu_start, pc_en, ifid_en, idex_en, exmem_en, memwb_en,
           ifid_flush, idex_flush, exmem_flush, memwb_flush,
           mem_fault, stall_cycles
  );

  // Sequencer side: consumes hazards, produces enables/flushes
  modport slave (
    input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_is_load,
           ex_branch_taken, ex_mdu_op, mdu_done, mem_req, dmem_ready,
    output mdu_start, pc_en, ifid_en, idex_en, exmem_en, memwb_en,
           ifid_flush, idex_flush, exmem_flush, memwb_flush,
           mem_fault, stall_cycles
  );
endinterface

// File: rtl/pipeline_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline. Resolves load-use
// hazards, taken-branch redirects, multi-cycle MDU ops and data-memory wait
// states. Flushes are ORed into each register's reset, so they beat enables.
module pipeline_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 64,
  parameter int          CNT_W       = 32,
  parameter int          REG_ADDR_W  = 5
) (
  input  logic           clk,
  input  logic           reset,
  pipeline_ctrl_if.slave bus
);

  typedef enum logic [1:0] {RUN, MEM_WAIT, MDU_WAIT, FAULT} state_e;

  localparam logic [15:0]      TIMEOUT = 16'(MEM_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_e           state_q, state_d;
  logic [15:0]      wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
  logic             mem_fault_q, mem_fault_d;

  logic [REG_ADDR_W-1:0] id_rs1, id_rs2, ex_rd;
  logic load_use, mem_stall, mdu_stall;

  logic pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic ifid_flush, idex_flush, exmem_flush, memwb_flush;
  logic mdu_start;

  assign id_rs1 = bus.id_rs1;
  assign id_rs2 = bus.id_rs2;
  assign ex_rd  = bus.ex_rd;

  // x0 is never a real dependency, so a load to x0 never stalls the consumer
  assign load_use  = bus.ex_is_load && (ex_rd != '0) &&
                     ((bus.id_use_rs1 && (id_rs1 == ex_rd)) ||
                      (bus.id_use_rs2 && (id_rs2 == ex_rd)));
  assign mem_stall = bus.mem_req && !bus.dmem_ready;
  assign mdu_stall = bus.ex_mdu_op && !bus.mdu_done;

  // State register plus timeout counter, stall counter and sticky fault flag
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= RUN;
      wait_cnt_q     <= '0;
      stall_cycles_q <= '0;
      mem_fault_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      wait_cnt_q     <= wait_cnt_d;
      stall_cycles_q <= stall_cycles_d;
      mem_fault_q    <= mem_fault_d;
    end
  end

  // Next-state: the timeout counter counts consecutive stalled memory cycles,
  // including the RUN cycle that first saw the stall, and faults on the edge
  // where that count reaches MEM_TIMEOUT
  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    mem_fault_d = mem_fault_q;
    case (state_q)
      RUN: begin
        if (mem_stall) begin
          if (TIMEOUT <= 16'd1) begin
            state_d     = FAULT;
            mem_fault_d = 1'b1;
            wait_cnt_d  = '0;
          end else begin
            state_d    = MEM_WAIT;
            wait_cnt_d = 16'd1;
          end
        end else if (mdu_stall) begin
          state_d = MDU_WAIT;
        end
      end
      MEM_WAIT: begin
        if (!mem_stall) begin
          state_d    = RUN;
          wait_cnt_d = '0;
        end else if ((wait_cnt_q + 16'd1) >= TIMEOUT) begin
          state_d     = FAULT;
          mem_fault_d = 1'b1;
          wait_cnt_d  = '0;
        end else begin
          wait_cnt_d = wait_cnt_q + 16'd1;
        end
      end
      MDU_WAIT: begin
        if (bus.mdu_done) state_d = RUN;
      end
      FAULT: begin
        state_d = FAULT;
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  // Output decode: reset bubbles everything, otherwise first matching hazard wins
  always_comb begin
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    idex_en     = 1'b1;
    exmem_en    = 1'b1;
    memwb_en    = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    memwb_flush = 1'b0;
    mdu_start   = 1'b0;
    if (reset) begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_en     = 1'b0;
      exmem_en    = 1'b0;
      memwb_en    = 1'b0;
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
      memwb_flush = 1'b1;
    end else if (state_q == FAULT) begin
      pc_en    = 1'b0;
      ifid_en  = 1'b0;
      idex_en  = 1'b0;
      exmem_en = 1'b0;
      memwb_en = 1'b0;
    end else begin
      mdu_start = (state_q == RUN) && bus.ex_mdu_op && !mem_stall;
      if (mem_stall) begin
        pc_en       = 1'b0;
        ifid_en     = 1'b0;
        idex_en     = 1'b0;
        exmem_en    = 1'b0;
        memwb_flush = 1'b1;
      end else if (mdu_stall) begin
        pc_en       = 1'b0;
        ifid_en     = 1'b0;
        idex_en     = 1'b0;
        exmem_flush = 1'b1;
      end else if (bus.ex_branch_taken) begin
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
      end else if (load_use) begin
        pc_en      = 1'b0;
        ifid_en    = 1'b0;
        idex_flush = 1'b1;
      end
    end
  end

  // Saturating count of cycles in which the PC is held
  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (!pc_en && (stall_cycles_q != CNT_MAX)) begin
      stall_cycles_d = stall_cycles_q + CNT_W'(1);
    end
  end

  assign bus.pc_en        = pc_en;
  assign bus.ifid_en      = ifid_en;
  assign bus.idex_en      = idex_en;
  assign bus.exmem_en     = exmem_en;
  assign bus.memwb_en     = memwb_en;
  assign bus.ifid_flush   = ifid_flush;
  assign bus.idex_flush   = idex_flush;
  assign bus.exmem_flush  = exmem_flush;
  assign bus.memwb_flush  = memwb_flush;
  assign bus.mdu_start    = mdu_start;
  assign bus.mem_fault    = mem_fault_q;
  assign bus.stall_cycles = stall_cycles_q;

endmodule
